// File: rtl/tri_st_rot_ins_pkg.sv
// Shared types for the rot/ins issue sequencer and its datapath.
//   op_e          : 4-bit issue opcode
//   ctl_t         : datapath control vector (log_fcn plus one-hot special controls)
//   rot_ins_decode: opcode -> ctl_t. An all-zero ctl_t marks an illegal opcode.
// Optional feature macro: ROT_INS_SEQ_PRTY_EN. When it is defined, PRTYW/PRTYD decode to
// the parity controls. When it is undefined, they decode as illegal.
package tri_st_rot_ins_pkg;

   localparam int ROT_W = 64;

   typedef enum logic [3:0] {
      OP_AND   = 4'h0, OP_ANDC  = 4'h1, OP_OR    = 4'h2, OP_XOR   = 4'h3,
      OP_NOR   = 4'h4, OP_EQV   = 4'h5, OP_NAND  = 4'h6, OP_ORC   = 4'h7,
      OP_CMPB  = 4'h8, OP_EXTSB = 4'h9, OP_EXTSH = 4'hA, OP_EXTSW = 4'hB,
      OP_SRAWF = 4'hC, OP_SRADF = 4'hD, OP_PRTYW = 4'hE, OP_PRTYD = 4'hF
   } op_e;

   // log_fcn[{rs_bit, rb_bit}] is the result bit. Index 0 is the leftmost digit.
   localparam logic [0:3] LF_AND  = 4'b0001;
   localparam logic [0:3] LF_ANDC = 4'b0010;
   localparam logic [0:3] LF_OR   = 4'b0111;
   localparam logic [0:3] LF_XOR  = 4'b0110;
   localparam logic [0:3] LF_NOR  = 4'b1000;
   localparam logic [0:3] LF_EQV  = 4'b1001;
   localparam logic [0:3] LF_NAND = 4'b1110;
   localparam logic [0:3] LF_ORC  = 4'b1011;

   typedef struct packed {
      logic [0:3] log_fcn;
      logic       cmp_byt;
      logic       sra_wd;
      logic       sra_dw;
      logic       xtd_byte;
      logic       xtd_half;
      logic       xtd_wd;
      logic       prtyw;
      logic       prtyd;
   } ctl_t;

   function automatic ctl_t rot_ins_decode(input logic [3:0] op);
      ctl_t c;
      c = '0;
      case (op_e'(op))
         OP_AND:   c.log_fcn = LF_AND;
         OP_ANDC:  c.log_fcn = LF_ANDC;
         OP_OR:    c.log_fcn = LF_OR;
         OP_XOR:   c.log_fcn = LF_XOR;
         OP_NOR:   c.log_fcn = LF_NOR;
         OP_EQV:   c.log_fcn = LF_EQV;
         OP_NAND:  c.log_fcn = LF_NAND;
         OP_ORC:   c.log_fcn = LF_ORC;
         OP_CMPB:  begin c.log_fcn = LF_EQV; c.cmp_byt = 1'b1; end
         OP_EXTSB: c.xtd_byte = 1'b1;
         OP_EXTSH: c.xtd_half = 1'b1;
         OP_EXTSW: c.xtd_wd   = 1'b1;
         OP_SRAWF: c.sra_wd   = 1'b1;
         OP_SRADF: c.sra_dw   = 1'b1;
`ifdef ROT_INS_SEQ_PRTY_EN
         OP_PRTYW: c.prtyw    = 1'b1;
         OP_PRTYD: c.prtyd    = 1'b1;
`endif
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tri_st_rot_ins.sv
// Combinational rotate/insert logical datapath.
//   rs, rb : operands
//   ctl    : decoded control vector
//   res    : result
// Bit numbering on the ports is LSB-0. Architected word 0 is res[63:32].
module tri_st_rot_ins
   import tri_st_rot_ins_pkg::*;
(
   input  logic [ROT_W-1:0] rs,
   input  logic [ROT_W-1:0] rb,
   input  ctl_t             ctl,
   output logic [ROT_W-1:0] res
);

   logic [ROT_W-1:0] log_res;
   logic [ROT_W-1:0] cmp_res;

   always_comb begin
      log_res = '0;
      for (int i = 0; i < ROT_W; i++) log_res[i] = ctl.log_fcn[{rs[i], rb[i]}];
      // CMPB runs EQV through the logic unit and then AND-reduces each byte.
      cmp_res = '0;
      for (int b = 0; b < ROT_W/8; b++) cmp_res[8*b +: 8] = {8{&log_res[8*b +: 8]}};

      res = log_res;
      if (ctl.cmp_byt)  res = cmp_res;
      if (ctl.xtd_byte) res = {{56{rs[7]}}, rs[7:0]};
      if (ctl.xtd_half) res = {{48{rs[15]}}, rs[15:0]};
      if (ctl.xtd_wd)   res = {{32{rs[31]}}, rs[31:0]};
      if (ctl.sra_wd)   res = {ROT_W{rs[31]}};
      if (ctl.sra_dw)   res = {ROT_W{rs[63]}};
      // The parity of the byte LSBs lands in the LSB of each word (prtyw) or of the doubleword (prtyd).
      if (ctl.prtyw) begin
         res     = '0;
         res[32] = rs[56] ^ rs[48] ^ rs[40] ^ rs[32];
         res[0]  = rs[24] ^ rs[16] ^ rs[8]  ^ rs[0];
      end
      if (ctl.prtyd) begin
         res    = '0;
         res[0] = rs[56] ^ rs[48] ^ rs[40] ^ rs[32] ^ rs[24] ^ rs[16] ^ rs[8] ^ rs[0];
      end
   end

endmodule

// File: rtl/tri_st_rot_ins_seq.sv
// Two-thread issue sequencer for the rot/ins datapath.
// The pipeline is: round-robin arbiter -> EX1 (decoded ctl + operands) -> datapath -> EX2 (result).
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_val/req_rdy[1:0]      per-thread handshake. A transfer is val & rdy.
//   req_op*/rs*/rb*/tag*      per-thread request payload
//   flush[1:0]                kills in-flight ops of that thread and blocks its request this cycle
//   res_val/res_rdy           result handshake. res_* hold while stalled.
//   res_tid/tag/data/err      result payload. err marks an illegal opcode, and then data is 0.
// Optional feature macro: ROT_INS_SEQ_PRTY_EN enables PRTYW/PRTYD. It is handled in the package decode.
module tri_st_rot_ins_seq
   import tri_st_rot_ins_pkg::*;
#(
   parameter int TAG_W  = 6,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_val,
   output logic [1:0]        req_rdy,
   input  logic [3:0]        req_op0,
   input  logic [3:0]        req_op1,
   input  logic [DATA_W-1:0] req_rs0,
   input  logic [DATA_W-1:0] req_rs1,
   input  logic [DATA_W-1:0] req_rb0,
   input  logic [DATA_W-1:0] req_rb1,
   input  logic [TAG_W-1:0]  req_tag0,
   input  logic [TAG_W-1:0]  req_tag1,
   input  logic [1:0]        flush,
   output logic              res_val,
   input  logic              res_rdy,
   output logic              res_tid,
   output logic [TAG_W-1:0]  res_tag,
   output logic [DATA_W-1:0] res_data,
   output logic              res_err
);

   logic              rr_ptr_q, rr_ptr_d;
   logic              ex1_vld_q, ex1_vld_d, ex1_tid_q, ex1_tid_d, ex1_err_q, ex1_err_d;
   logic [TAG_W-1:0]  ex1_tag_q, ex1_tag_d;
   ctl_t              ex1_ctl_q, ex1_ctl_d;
   logic [DATA_W-1:0] ex1_rs_q, ex1_rs_d, ex1_rb_q, ex1_rb_d;
   logic              ex2_vld_q, ex2_vld_d, ex2_tid_q, ex2_tid_d, ex2_err_q, ex2_err_d;
   logic [TAG_W-1:0]  ex2_tag_q, ex2_tag_d;
   logic [DATA_W-1:0] ex2_data_q, ex2_data_d;

   logic [1:0]        elig, grant;
   logic              ex1_kill, ex2_kill, ex2_free, ex1_free, ex1_adv, acc, acc_tid;
   ctl_t              acc_ctl;
   logic [DATA_W-1:0] dp_res;

   tri_st_rot_ins u_dp (.rs(ex1_rs_q), .rb(ex1_rb_q), .ctl(ex1_ctl_q), .res(dp_res));

   // A flushed entry frees its stage in the same cycle, so younger work can move up behind it.
   always_comb begin
      ex2_kill = ex2_vld_q & flush[ex2_tid_q];
      ex1_kill = ex1_vld_q & flush[ex1_tid_q];
      ex2_free = ~ex2_vld_q | res_rdy | ex2_kill;
      ex1_adv  = ex1_vld_q & ~ex1_kill & ex2_free;
      ex1_free = ~ex1_vld_q | ex1_kill | ex2_free;
   end

   // Arbiter: a flushed thread is not eligible, so it cannot steal the grant from the other thread.
   always_comb begin
      elig  = req_val & ~flush;
      grant = elig;
      if (&elig) grant = rr_ptr_q ? 2'b10 : 2'b01;
      req_rdy  = rst ? 2'b00 : (grant & {2{ex1_free}});
      acc      = |req_rdy;
      acc_tid  = req_rdy[1];
      rr_ptr_d = acc ? ~acc_tid : rr_ptr_q;
   end

   always_comb begin
      acc_ctl   = rot_ins_decode(acc_tid ? req_op1 : req_op0);
      ex1_vld_d = ex1_vld_q;
      ex1_tid_d = ex1_tid_q;
      ex1_tag_d = ex1_tag_q;
      ex1_ctl_d = ex1_ctl_q;
      ex1_err_d = ex1_err_q;
      ex1_rs_d  = ex1_rs_q;
      ex1_rb_d  = ex1_rb_q;
      if (ex1_free) ex1_vld_d = acc;
      if (acc) begin
         ex1_tid_d = acc_tid;
         ex1_tag_d = acc_tid ? req_tag1 : req_tag0;
         ex1_ctl_d = acc_ctl;
         ex1_err_d = (acc_ctl == '0);
         ex1_rs_d  = acc_tid ? req_rs1 : req_rs0;
         ex1_rb_d  = acc_tid ? req_rb1 : req_rb0;
      end

      ex2_vld_d  = ex2_vld_q;
      ex2_tid_d  = ex2_tid_q;
      ex2_tag_d  = ex2_tag_q;
      ex2_err_d  = ex2_err_q;
      ex2_data_d = ex2_data_q;
      if (ex2_free) ex2_vld_d = ex1_adv;
      if (ex1_adv) begin
         ex2_tid_d  = ex1_tid_q;
         ex2_tag_d  = ex1_tag_q;
         ex2_err_d  = ex1_err_q;
         ex2_data_d = ex1_err_q ? '0 : dp_res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= 1'b0;
         ex1_vld_q  <= 1'b0;
         ex1_tid_q  <= 1'b0;
         ex1_tag_q  <= '0;
         ex1_ctl_q  <= '0;
         ex1_err_q  <= 1'b0;
         ex1_rs_q   <= '0;
         ex1_rb_q   <= '0;
         ex2_vld_q  <= 1'b0;
         ex2_tid_q  <= 1'b0;
         ex2_tag_q  <= '0;
         ex2_err_q  <= 1'b0;
         ex2_data_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         ex1_vld_q  <= ex1_vld_d;
         ex1_tid_q  <= ex1_tid_d;
         ex1_tag_q  <= ex1_tag_d;
         ex1_ctl_q  <= ex1_ctl_d;
         ex1_err_q  <= ex1_err_d;
         ex1_rs_q   <= ex1_rs_d;
         ex1_rb_q   <= ex1_rb_d;
         ex2_vld_q  <= ex2_vld_d;
         ex2_tid_q  <= ex2_tid_d;
         ex2_tag_q  <= ex2_tag_d;
         ex2_err_q  <= ex2_err_d;
         ex2_data_q <= ex2_data_d;
      end
   end

   assign res_val  = ex2_vld_q;
   assign res_tid  = ex2_tid_q;
   assign res_tag  = ex2_tag_q;
   assign res_data = ex2_data_q;
   assign res_err  = ex2_err_q;

endmodule

// File: tb/tb_tri_st_rot_ins_seq.sv
// Bench for tri_st_rot_ins_seq. It drives directed cases and then random traffic.
// A queue holds the in-flight ops in accept order, and their results are computed from the opcode rules.
module tb_tri_st_rot_ins_seq;
   import tri_st_rot_ins_pkg::*;

   logic        clk = 1'b0, rst = 1'b1;
   logic [1:0]  req_val = '0, req_rdy, flush = '0;
   logic [3:0]  req_op0 = '0, req_op1 = '0;
   logic [63:0] req_rs0 = '0, req_rs1 = '0, req_rb0 = '0, req_rb1 = '0;
   logic [5:0]  req_tag0 = '0, req_tag1 = '0;
   logic        res_val, res_rdy = 1'b1, res_tid, res_err;
   logic [5:0]  res_tag;
   logic [63:0] res_data;

   always #5 clk = ~clk;

   tri_st_rot_ins_seq #(.TAG_W(6), .DATA_W(64)) dut (
      .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy),
      .req_op0(req_op0), .req_op1(req_op1), .req_rs0(req_rs0), .req_rs1(req_rs1),
      .req_rb0(req_rb0), .req_rb1(req_rb1), .req_tag0(req_tag0), .req_tag1(req_tag1),
      .flush(flush), .res_val(res_val), .res_rdy(res_rdy), .res_tid(res_tid),
      .res_tag(res_tag), .res_data(res_data), .res_err(res_err));

   typedef struct {
      logic        tid;
      logic [5:0]  tag;
      logic [63:0] data;
      logic        err;
   } exp_t;

   exp_t        q[$];
   int          total = 0, bad = 0;
   logic        ptr = 1'b0, stall_prev = 1'b0, rst_prev = 1'b0;
   logic        h_tid, h_err;
   logic [5:0]  h_tag;
   logic [63:0] h_data;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void ref_op(input logic [3:0] op, input logic [63:0] rs, input logic [63:0] rb,
                                  output logic [63:0] d, output logic e);
      d = '0;
      e = 1'b0;
      case (op)
         OP_AND:   d = rs & rb;
         OP_ANDC:  d = rs & ~rb;
         OP_OR:    d = rs | rb;
         OP_XOR:   d = rs ^ rb;
         OP_NOR:   d = ~(rs | rb);
         OP_EQV:   d = ~(rs ^ rb);
         OP_NAND:  d = ~(rs & rb);
         OP_ORC:   d = rs | ~rb;
         OP_CMPB:  for (int b = 0; b < 8; b++) d[8*b +: 8] = (rs[8*b +: 8] == rb[8*b +: 8]) ? 8'hFF : 8'h00;
         OP_EXTSB: d = 64'(signed'(rs[7:0]));
         OP_EXTSH: d = 64'(signed'(rs[15:0]));
         OP_EXTSW: d = 64'(signed'(rs[31:0]));
         OP_SRAWF: d = rs[31] ? '1 : '0;
         OP_SRADF: d = rs[63] ? '1 : '0;
`ifdef ROT_INS_SEQ_PRTY_EN
         OP_PRTYW: begin
            for (int b = 4; b < 8; b++) d[32] = d[32] ^ rs[8*b];
            for (int b = 0; b < 4; b++) d[0]  = d[0]  ^ rs[8*b];
         end
         OP_PRTYD: for (int b = 0; b < 8; b++) d[0] = d[0] ^ rs[8*b];
`endif
         default:  e = 1'b1;
      endcase
   endfunction

   // Inputs are set at the falling edge. This task checks the cycle, updates the model and
   // moves on to the next falling edge.
   task automatic cyc();
      logic [1:0] elig;
      logic       at;
      exp_t       e, nq[$];
      #1;
      if (rst) begin
         chk("rst_rdy", {62'd0, req_rdy}, 64'd0);
         q.delete();
         ptr = 1'b0; stall_prev = 1'b0; rst_prev = 1'b1;
      end else begin
         if (rst_prev) chk("rst_drop", {63'd0, res_val}, 64'd0);
         rst_prev = 1'b0;
         if (stall_prev) begin
            chk("hold_val",  {63'd0, res_val}, 64'd1);
            chk("hold_tid",  {63'd0, res_tid}, {63'd0, h_tid});
            chk("hold_tag",  {58'd0, res_tag}, {58'd0, h_tag});
            chk("hold_data", res_data, h_data);
            chk("hold_err",  {63'd0, res_err}, {63'd0, h_err});
         end
         elig = req_val & ~flush;
         chk("rdy_elig", {62'd0, req_rdy & ~elig}, 64'd0);
         chk("rdy_both", {63'd0, &req_rdy}, 64'd0);
         if (&elig && |req_rdy) chk("rr_ptr", {63'd0, req_rdy[1]}, {63'd0, ptr});
         if (q.size() == 0 && |elig) chk("live", {63'd0, |req_rdy}, 64'd1);
         if (res_val && res_rdy && !flush[res_tid]) begin
            if (q.size() == 0) chk("extra_res", {63'd0, res_val}, 64'd0);
            else begin
               e = q.pop_front();
               chk("res_tid",  {63'd0, res_tid}, {63'd0, e.tid});
               chk("res_tag",  {58'd0, res_tag}, {58'd0, e.tag});
               chk("res_data", res_data, e.data);
               chk("res_err",  {63'd0, res_err}, {63'd0, e.err});
            end
         end
         foreach (q[i]) if (!flush[q[i].tid]) nq.push_back(q[i]);
         q = nq;
         if (|req_rdy) begin
            at    = req_rdy[1];
            e.tid = at;
            e.tag = at ? req_tag1 : req_tag0;
            ref_op(at ? req_op1 : req_op0, at ? req_rs1 : req_rs0, at ? req_rb1 : req_rb0, e.data, e.err);
            q.push_back(e);
            ptr = ~at;
         end
         chk("depth", {63'd0, q.size() <= 2}, 64'd1);
         stall_prev = res_val & ~res_rdy & ~flush[res_tid];
         h_tid = res_tid; h_tag = res_tag; h_data = res_data; h_err = res_err;
      end
      @(negedge clk);
   endtask

   task automatic one(input string nm, input logic [3:0] op, input logic [63:0] rs, input logic [63:0] rb,
                      input logic [63:0] ed, input logic ee);
      req_val = 2'b01; req_op0 = op; req_rs0 = rs; req_rb0 = rb; req_tag0 = 6'h2A;
      cyc();
      req_val = 2'b00;
      cyc();
      chk({nm, "_val"}, {63'd0, res_val}, 64'd1);
      chk({nm, "_data"}, res_data, ed);
      chk({nm, "_err"}, {63'd0, res_err}, {63'd0, ee});
      cyc();
   endtask

   initial begin
      @(negedge clk);
      cyc();
      cyc();
      chk("rst_val",  {63'd0, res_val}, 64'd0);
      chk("rst_tid",  {63'd0, res_tid}, 64'd0);
      chk("rst_tag",  {58'd0, res_tag}, 64'd0);
      chk("rst_data", res_data, 64'd0);
      chk("rst_err",  {63'd0, res_err}, 64'd0);
      rst = 1'b0;

      // 1: latency of a single AND
      req_val = 2'b01; req_op0 = OP_AND; req_tag0 = 6'd5;
      req_rs0 = 64'hFF00FF00_FF00FF00; req_rb0 = 64'h0F0F0F0F_0F0F0F0F;
      #1 chk("t1_rdy", {62'd0, req_rdy}, 64'd1);
      cyc();
      req_val = 2'b00;
      chk("t1_ex1", {63'd0, res_val}, 64'd0);
      cyc();
      chk("t1_val",  {63'd0, res_val}, 64'd1);
      chk("t1_data", res_data, 64'h0F000F00_0F000F00);
      chk("t1_tid",  {63'd0, res_tid}, 64'd0);
      chk("t1_tag",  {58'd0, res_tag}, 64'd5);
      cyc();

      // 2: both threads always valid, starting from a fresh reset
      rst = 1'b1; cyc(); rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         req_val = 2'b11;
         req_op0 = 4'($urandom_range(0, 15)); req_op1 = 4'($urandom_range(0, 15));
         req_rs0 = {$urandom, $urandom}; req_rs1 = {$urandom, $urandom};
         req_tag0 = 6'(i); req_tag1 = 6'(i + 32);
         #1 chk("t2_gnt", {62'd0, req_rdy}, (i % 2) ? 64'd2 : 64'd1);
         if (i >= 2) begin
            chk("t2_thru", {63'd0, res_val}, 64'd1);
            chk("t2_tid", {63'd0, res_tid}, 64'((i - 2) % 2));
         end
         cyc();
      end
      req_val = 2'b00; cyc(); cyc(); cyc();

      // 3, 4: decode corners
      one("cmpb", OP_CMPB, 64'h11223344_55667788, 64'h11003344_00667700, 64'hFF00FFFF_00FFFF00, 1'b0);
      one("extsh", OP_EXTSH, 64'h12345678_00008001, 64'h0, 64'hFFFFFFFF_FFFF8001, 1'b0);
      one("srawf1", OP_SRAWF, 64'h00000001_80000000, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
      one("srawf0", OP_SRAWF, 64'h80000000_7FFFFFFF, 64'h0, 64'h0, 1'b0);
`ifdef ROT_INS_SEQ_PRTY_EN
      one("prtyd", OP_PRTYD, 64'h00000000_00000001, 64'h0, 64'h1, 1'b0);
`else
      one("prtyd", OP_PRTYD, 64'h00000000_00000001, 64'h0, 64'h0, 1'b1);
`endif

      // 5: consumer stalls with both stages full
      res_rdy = 1'b0;
      req_val = 2'b01; req_op0 = OP_XOR; req_tag0 = 6'd11; cyc();
      req_val = 2'b10; req_op1 = OP_OR;  req_tag1 = 6'd12; cyc();
      req_val = 2'b11;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t5_full", {62'd0, req_rdy}, 64'd0);
         cyc();
      end
      req_val = 2'b00; res_rdy = 1'b1;
      cyc(); cyc(); cyc();
      chk("t5_drain", 64'(q.size()), 64'd0);

      // 6: flush a stalled T1 result while a T0 PRTYW waits in EX1
      res_rdy = 1'b0;
      req_val = 2'b10; req_op1 = OP_AND; req_tag1 = 6'd21; cyc();
      req_val = 2'b01; req_op0 = OP_PRTYW; req_tag0 = 6'd22; req_rs0 = 64'h01000000_00000000; cyc();
      req_val = 2'b00; flush = 2'b10; cyc();
      flush = 2'b00;
      chk("t6_val", {63'd0, res_val}, 64'd1);
      chk("t6_tid", {63'd0, res_tid}, 64'd0);
      chk("t6_tag", {58'd0, res_tag}, 64'd22);
`ifdef ROT_INS_SEQ_PRTY_EN
      chk("t6_data", res_data, 64'h00000001_00000000);
      chk("t6_err", {63'd0, res_err}, 64'd0);
`else
      chk("t6_data", res_data, 64'h0);
      chk("t6_err", {63'd0, res_err}, 64'd1);
`endif
      res_rdy = 1'b1; cyc();
      chk("t6_gone", {63'd0, res_val}, 64'd0);
      cyc();

      // random traffic with one reset in the middle
      for (int i = 0; i < 600; i++) begin
         rst      = (i == 300);
         req_val  = 2'($urandom);
         res_rdy  = ($urandom_range(0, 3) != 0);
         flush    = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
         req_op0  = 4'($urandom_range(0, 15)); req_op1 = 4'($urandom_range(0, 15));
         req_tag0 = 6'($urandom); req_tag1 = 6'($urandom);
         req_rs0  = {$urandom, $urandom}; req_rs1 = {$urandom, $urandom};
         req_rb0  = $urandom_range(0, 1) ? {$urandom, $urandom} : req_rs0 ^ {8{8'($urandom_range(0, 1))}};
         req_rb1  = $urandom_range(0, 1) ? {$urandom, $urandom} : req_rs1 & {$urandom, $urandom};
         cyc();
      end
      rst = 1'b0; req_val = 2'b00; flush = 2'b00; res_rdy = 1'b1;
      cyc(); cyc(); cyc();
      chk("final_drain", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
